// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: grant types and helpers shared by the round-robin arbiter and its collector.
// The helpers take a 16-bit grant so any REQS in 2..16 can use them after zero-extension.
package rr_arb_pkg;
    localparam int REQS = 4;
    localparam int MAX_REQS = 16;
    typedef logic [REQS-1:0] grant_t;
    typedef logic [$clog2(REQS)-1:0] src_t;
    typedef logic [MAX_REQS-1:0] grant_max_t;
    typedef logic [$clog2(MAX_REQS)-1:0] src_max_t;
    function automatic src_max_t onehot_to_idx(grant_max_t g);
        src_max_t idx = '0;
        for (int i = 0; i < MAX_REQS; i++) idx |= g[i] ? src_max_t'(i) : '0;
        return idx;
    endfunction
    function automatic logic is_onehot(grant_max_t g);
        return g != '0 && (g & (g - grant_max_t'(1))) == '0;
    endfunction
endpackage

// File: rtl/rr_grant_collector_if.sv
// rr_grant_collector_if: grant/payload inputs from the arbiter side and the queued output stream.
interface rr_grant_collector_if #(
    parameter int REQS = rr_arb_pkg::REQS,
    parameter int DW = 8,
    parameter int SW = $clog2(REQS)
);
    logic [REQS-1:0] grants_i;
    logic any_grant_i;
    logic [REQS*DW-1:0] payload_i;
    logic [REQS-1:0] ack_o;
    logic out_valid_o;
    logic out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [SW-1:0] out_src_o;
    logic grant_err_o;
    logic [1:0] count_o;
    modport slave (
        input grants_i, any_grant_i, payload_i, out_ready_i,
        output ack_o, out_valid_o, out_data_o, out_src_o, grant_err_o, count_o
    );
    modport master (
        output grants_i, any_grant_i, payload_i, out_ready_i,
        input ack_o, out_valid_o, out_data_o, out_src_o, grant_err_o, count_o
    );
endinterface

// File: rtl/rr_fifo2.sv
// rr_fifo2: two-entry FIFO; a push while full is dropped even if a pop happens the same cycle.
// The head is held in its own register so it keeps the last value once the FIFO drains.
module rr_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic [W-1:0] dout_q, dout_d;
    logic rptr_q, rptr_d, wptr_q, wptr_d;
    logic [1:0] count_q, count_d;
    logic do_push, do_pop;
    always_comb begin
        do_push = push_i && count_q != 2'd2;
        do_pop = pop_i && count_q != 2'd0;
        mem_d = mem_q;
        if (do_push) mem_d[wptr_q] = din_i;
        wptr_d = wptr_q ^ do_push;
        rptr_d = rptr_q ^ do_pop;
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        dout_d = count_d != 2'd0 ? mem_d[rptr_d] : dout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            dout_q <= '0;
            rptr_q <= 1'b0;
            wptr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            dout_q <= dout_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            count_q <= count_d;
        end
    end
    assign dout_o = dout_q;
    assign valid_o = count_q != 2'd0;
    assign count_o = count_q;
endmodule

// File: rtl/rr_grant_collector.sv
// rr_grant_collector: checks arbiter grants, acks and queues the winner's payload with its index.
module rr_grant_collector import rr_arb_pkg::*; #(
    parameter int REQS = rr_arb_pkg::REQS,
    parameter int DW = 8
) (
    input logic clk,
    input logic rst,
    rr_grant_collector_if.slave bus
);
    localparam int SW = $clog2(REQS);
    grant_max_t g_ext;
    logic [SW-1:0] idx;
    logic legal, illegal, push, err_q, err_d;
    logic [DW+SW-1:0] head;
    logic [1:0] count;
    always_comb begin
        g_ext = grant_max_t'(bus.grants_i);
        legal = bus.any_grant_i && is_onehot(g_ext);
        illegal = bus.any_grant_i ? !legal : g_ext != '0;
        idx = SW'(onehot_to_idx(g_ext));
        // acceptance looks only at the registered occupancy, never at out_ready_i
        push = legal && count != 2'd2 && !rst;
        err_d = err_q || illegal;
    end
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else err_q <= err_d;
    end
    rr_fifo2 #(.W(DW + SW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(push),
        .pop_i(bus.out_valid_o && bus.out_ready_i),
        .din_i({bus.payload_i[int'(idx)*DW +: DW], idx}),
        .dout_o(head),
        .valid_o(bus.out_valid_o),
        .count_o(count)
    );
    assign bus.ack_o = push ? bus.grants_i : '0;
    assign bus.out_data_o = head[DW+SW-1:SW];
    assign bus.out_src_o = head[SW-1:0];
    assign bus.grant_err_o = err_q;
    assign bus.count_o = count;
endmodule

// File: tb/tb_rr_grant_collector.sv
// tb_rr_grant_collector: directed vector table followed by random traffic against a queue model.
module tb_rr_grant_collector;
    localparam int N = 4;
    localparam int DW = 8;
    typedef struct {
        logic r; logic [3:0] g; logic any; logic rdy;
        logic [3:0] ack; logic v; logic [1:0] src; logic [7:0] d; logic [1:0] cnt; logic err;
    } vec_t;
    typedef struct { logic [7:0] d; logic [1:0] s; } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    vec_t tbl [26];
    ent_t q [$];
    ent_t last_m;
    logic err_m;
    always #5 clk = ~clk;
    rr_grant_collector_if #(.REQS(N), .DW(DW)) bus ();
    rr_grant_collector #(.REQS(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic vec_t mk(logic r, logic [3:0] g, logic any, logic rdy, logic [3:0] ack,
                                logic v, logic [1:0] src, logic [7:0] d, logic [1:0] cnt, logic err);
        vec_t t;
        t.r = r; t.g = g; t.any = any; t.rdy = rdy; t.ack = ack;
        t.v = v; t.src = src; t.d = d; t.cnt = cnt; t.err = err;
        return t;
    endfunction
    task automatic check(string nm, int n, logic [3:0] ack, logic v, logic [1:0] src,
                         logic [7:0] d, logic [1:0] cnt, logic err);
        vectors++;
        if ({bus.ack_o, bus.out_valid_o, bus.out_src_o, bus.out_data_o, bus.count_o, bus.grant_err_o}
            !== {ack, v, src, d, cnt, err}) begin
            miscompares++;
            $display("FAIL %s %0d: got ack=%b v=%b src=%0d data=%h cnt=%0d err=%b, want ack=%b v=%b src=%0d data=%h cnt=%0d err=%b",
                     nm, n, bus.ack_o, bus.out_valid_o, bus.out_src_o, bus.out_data_o, bus.count_o,
                     bus.grant_err_o, ack, v, src, d, cnt, err);
        end
    endtask
    initial begin
        tbl[0]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 0);
        tbl[3]  = mk(0, 4'h1, 1, 1, 4'h1, 0, 0, 8'h00, 0, 0);
        tbl[4]  = mk(0, 4'h2, 1, 1, 4'h2, 1, 0, 8'hA0, 1, 0);
        tbl[5]  = mk(0, 4'h4, 1, 1, 4'h4, 1, 1, 8'hA1, 1, 0);
        tbl[6]  = mk(0, 4'h8, 1, 1, 4'h8, 1, 2, 8'hA2, 1, 0);
        tbl[7]  = mk(0, 4'h0, 0, 1, 4'h0, 1, 3, 8'hA3, 1, 0);
        tbl[8]  = mk(0, 4'h4, 1, 0, 4'h4, 0, 3, 8'hA3, 0, 0);
        tbl[9]  = mk(0, 4'h1, 1, 0, 4'h1, 1, 2, 8'hA2, 1, 0);
        tbl[10] = mk(0, 4'h8, 1, 0, 4'h0, 1, 2, 8'hA2, 2, 0);
        tbl[11] = mk(0, 4'h8, 1, 1, 4'h0, 1, 2, 8'hA2, 2, 0);
        tbl[12] = mk(0, 4'h8, 1, 1, 4'h8, 1, 0, 8'hA0, 1, 0);
        tbl[13] = mk(0, 4'h2, 1, 1, 4'h2, 1, 3, 8'hA3, 1, 0);
        tbl[14] = mk(0, 4'h0, 0, 0, 4'h0, 1, 1, 8'hA1, 1, 0);
        tbl[15] = mk(0, 4'h6, 1, 0, 4'h0, 1, 1, 8'hA1, 1, 0);
        tbl[16] = mk(0, 4'h1, 1, 0, 4'h1, 1, 1, 8'hA1, 1, 1);
        tbl[17] = mk(0, 4'h0, 0, 1, 4'h0, 1, 1, 8'hA1, 2, 1);
        tbl[18] = mk(0, 4'h0, 0, 1, 4'h0, 1, 0, 8'hA0, 1, 1);
        tbl[19] = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 8'hA0, 0, 1);
        tbl[20] = mk(1, 4'h0, 0, 0, 4'h0, 0, 0, 8'hA0, 0, 1);
        tbl[21] = mk(0, 4'h8, 0, 0, 4'h0, 0, 0, 8'h00, 0, 0);
        tbl[22] = mk(0, 4'h4, 1, 0, 4'h4, 0, 0, 8'h00, 0, 1);
        tbl[23] = mk(0, 4'h2, 1, 0, 4'h2, 1, 2, 8'hA2, 1, 1);
        tbl[24] = mk(1, 4'h1, 1, 0, 4'h0, 1, 2, 8'hA2, 2, 1);
        tbl[25] = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 0);
        rst = 1'b1;
        bus.grants_i = '0;
        bus.any_grant_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.payload_i = 32'hA3A2A1A0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst = tbl[i].r;
            bus.grants_i = tbl[i].g;
            bus.any_grant_i = tbl[i].any;
            bus.out_ready_i = tbl[i].rdy;
            #1;
            check("table", i, tbl[i].ack, tbl[i].v, tbl[i].src, tbl[i].d, tbl[i].cnt, tbl[i].err);
        end
        // model state after the last table row: empty, no error, head register cleared by reset
        err_m = 1'b0;
        last_m = '{d: 8'h00, s: 2'd0};
        for (int c = 0; c < 3000; c++) begin
            int choice, pc;
            logic legal, full;
            logic [1:0] idx;
            ent_t head;
            @(negedge clk);
            choice = $urandom_range(0, 9);
            rst = $urandom_range(0, 99) == 0;
            bus.grants_i = choice < 6 ? 4'b0001 << $urandom_range(0, 3) : choice < 8 ? 4'h0 : 4'($urandom);
            bus.any_grant_i = choice < 6 ? 1'b1 : choice < 8 ? 1'b0 : 1'($urandom);
            bus.out_ready_i = $urandom_range(0, 2) != 0;
            bus.payload_i = $urandom;
            #1;
            pc = $countones(bus.grants_i);
            legal = bus.any_grant_i && pc == 1;
            idx = 2'd0;
            for (int k = 0; k < N; k++) if (bus.grants_i[k]) idx = 2'(k);
            head = q.size() > 0 ? q[0] : last_m;
            check("random", c, (!rst && legal && q.size() < 2) ? bus.grants_i : 4'h0,
                  q.size() > 0, head.s, head.d, 2'(q.size()), err_m);
            if (rst) begin
                q.delete();
                err_m = 1'b0;
                last_m = '{d: 8'h00, s: 2'd0};
            end else begin
                full = q.size() == 2;
                if (q.size() > 0 && bus.out_ready_i) void'(q.pop_front());
                if (legal && !full) q.push_back('{d: bus.payload_i[int'(idx)*DW +: DW], s: idx});
                if (bus.any_grant_i ? pc != 1 : bus.grants_i != 4'h0) err_m = 1'b1;
            end
            if (q.size() > 0) last_m = q[0];
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_grant_collector.md
Name: rr_grant_collector

Overview:
- Downstream stage of the round-robin arbiter. Consumes its one-hot grant vector and any-grant flag.
- Selects the winning requester's payload and returns a one-cycle accept pulse to that requester.
- Queues the payload with its source index in a 2-entry FIFO toward a valid/ready consumer.
- Checks the arbiter's grant outputs for legality (one-hot, consistent with any-grant) and flags violations stickily.

Parameters:
- REQS, 4, number of requesters; must match the arbiter's REQS; legal values 2..16.
- DW, 8, payload width per requester in bits.
- SW, $clog2(REQS), source index width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- grants_i  in  REQS  one-hot grant vector from the arbiter's grants_o.
- any_grant_i  in  1  arbiter's any_grant_o.
- payload_i  in  REQS*DW  requester payloads; requester k occupies bits [k*DW +: DW].
- ack_o  out  REQS  one-hot accept pulse; requester k drops or advances its request on ack_o[k].
- out_valid_o  out  1  FIFO head is valid.
- out_ready_i  in  1  consumer accepts the head this cycle.
- out_data_o  out  DW  head payload.
- out_src_o  out  SW  head source index.
- grant_err_o  out  1  sticky illegal-grant flag.
- count_o  out  2  FIFO occupancy, 0..2.

Behaviour:
- Clock and reset: one clock domain.
  - rst is synchronous and active-high.
  - On reset: FIFO emptied; count_o=0, out_valid_o=0, out_data_o=0, out_src_o=0, grant_err_o=0.
  - ack_o is 0 during the reset cycle.
- Legal grant: any_grant_i==1 and grants_i has exactly one bit set.
- Illegal grant, either case:
  - any_grant_i==1 and popcount(grants_i)!=1;
  - any_grant_i==0 and grants_i!=0.
  - Effect: grant_err_o set the next cycle and held until rst. No push, no ack that cycle.
  - Block keeps operating on subsequent legal grants.
- Push condition: legal grant and count<2, with count the registered value.
  - Push does not depend on out_ready_i; there is no combinational ready-to-ack path.
  - On push: ack_o = grants_i, combinationally in the same cycle. Entry {payload of idx, idx} is written at the clock edge, idx = one-hot-to-binary of grants_i.
  - When count==2, a legal grant is not accepted: ack_o=0 and the requester holds its request.
  - A push while full is never performed, even if a pop occurs in the same cycle.
- Pop: out_valid_o && out_ready_i at a clock edge removes the head.
- Latency:
  - Push in cycle N makes the entry visible at the head in cycle N+1 if the FIFO was empty, otherwise behind the existing entry.
  - Zero bubble: with out_ready_i held at 1, a grant in every cycle gives out_valid_o continuously high.
- Simultaneous push and pop with count==1: count stays 1, old head leaves, new entry becomes head.
- Ordering: strict FIFO.
  - out_data_o and out_src_o are stable while out_valid_o=1 and out_ready_i=0.
  - When out_valid_o=0: out_data_o and out_src_o hold their last value.
- Storage:
  - Two registered entries with a 1-bit read pointer and a 1-bit write pointer, each wrapping 1→0.
  - count_o is a 2-bit register. No overflow or underflow is possible by construction.
- Reset mid-operation: queued entries are discarded; any grant presented in the reset cycle is ignored and not acked.

Decomposition:
- Shared package rr_arb_pkg:
  - default REQS;
  - typedef grant_t as logic[REQS-1:0];
  - typedef src_t as logic[$clog2(REQS)-1:0];
  - function onehot_to_idx(grant_t) returning src_t;
  - function is_onehot(grant_t).
- The arbiter and its testbench import the same package.
- One natural sub-module: rr_fifo2, a parameterised 2-entry FIFO with push/pop/count of width DW+SW. The collector is the grant check, the payload mux and the ack logic around it.

Test Plan:
- Reset then grants_i=0000, any=0 for 3 cycles → out_valid_o=0, ack_o=0000, count_o=0, grant_err_o=0.
- payload k=8'hA0+k; grants 0001,0010,0100,1000 on consecutive cycles with out_ready_i=1 → ack_o mirrors each grant; out_src_o 0,1,2,3 with data A0..A3, each one cycle after its grant; out_valid_o continuously high.
- out_ready_i=0; grants 0100,0001,1000 → first two acked, count_o=2; third gives ack_o=0000. Then out_ready_i=1 → pops src 2 then 0; 1000 acked once count_o<2.
- count_o=1 with out_ready_i=1 and grant 0010 in the same cycle → count_o stays 1, next head src=1.
- grants_i=0110 with any=1 → ack_o=0000, no push, grant_err_o=1 next cycle and held; then legal 0001 → acked normally.
- grants_i=1000 with any=0 → grant_err_o=1. Assert rst mid-queue with count_o=2 → count_o=0, out_valid_o=0, grant_err_o=0 the next cycle.
